alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential RV ALU with multi-cycle shifter
// and a valid/ready handshake on request and result.
//
// Ports:
//   clock, reset_n      clock, async active-low reset
//   flush               synchronous abort of all work
//   in_valid/in_ready   request handshake
//   insn30, funct3, w   operation select (w: 32-bit op)
//   op1, op2            operands
//   out_valid/out_ready result handshake
//   result              registered result
//   busy                high while shifting
module alu_seq #(
   parameter int XLEN       = 64,
   parameter int SHIFT_STEP = 4
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            insn30,
   input  logic [2:0]      funct3,
   input  logic            w,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int LW = $clog2(XLEN);
   localparam int CW = LW + 1;
   localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [2:0] F_ADDSUB = 3'd0;
   localparam logic [2:0] F_SLL    = 3'd1;
   localparam logic [2:0] F_SLT    = 3'd2;
   localparam logic [2:0] F_SLTU   = 3'd3;
   localparam logic [2:0] F_XOR    = 3'd4;
   localparam logic [2:0] F_SR     = 3'd5;
   localparam logic [2:0] F_OR     = 3'd6;
   localparam logic [2:0] F_AND    = 3'd7;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            dir_q, dir_d;
   logic            arith_q, arith_d;
   logic            wop_q, wop_d;

   logic            wop;
   logic [LW-1:0]   amt;
   logic            is_shift;
   logic [XLEN-1:0] sr_src;
   logic [XLEN-1:0] raw;
   logic [XLEN-1:0] quick;
   logic            accept;
   logic [CW-1:0]   step;
   logic            last;
   logic [XLEN-1:0] sh_r;
   logic [XLEN-1:0] sh_l;
   logic [XLEN-1:0] sh_val;

   function automatic logic [XLEN-1:0] wext(
      input logic [XLEN-1:0] v,
      input logic            en
   );
      logic [XLEN-1:0] r;
      r = v;
      if (en) begin
         for (int i = 32; i < XLEN; i++) begin
            r[i] = v[31];
         end
      end
      return r;
   endfunction

   assign wop      = (XLEN == 64) && w;
   assign is_shift = (funct3 == F_SLL) ||
                     (funct3 == F_SR);

   always_comb begin
      amt = '0;
      if (wop) begin
         amt[4:0] = op2[4:0];
      end else begin
         amt = op2[LW-1:0];
      end
   end

   // Word right shifts work on op1[31:0], upper half
   // pre-filled so the shifter only ever sees XLEN bits.
   always_comb begin
      sr_src = op1;
      if (wop) begin
         for (int i = 32; i < XLEN; i++) begin
            sr_src[i] = op1[31] & insn30;
         end
      end
   end

   always_comb begin
      raw = '0;
      unique case (funct3)
         F_ADDSUB: raw = insn30 ? op1 - op2 : op1 + op2;
         F_SLL:    raw = op1;
         F_SLT:    raw[0] = $signed(op1) < $signed(op2);
         F_SLTU:   raw[0] = op1 < op2;
         F_XOR:    raw = op1 ^ op2;
         F_SR:     raw = sr_src;
         F_OR:     raw = op1 | op2;
         F_AND:    raw = op1 & op2;
      endcase
   end

   assign quick = wext(raw, wop);

   assign in_ready = reset_n & ~flush &
                     ((state_q == S_IDLE) |
                      ((state_q == S_DONE) & out_ready));
   assign accept   = in_valid & in_ready;

   // Arithmetic shifts keep the sign in the MSB of the
   // working value, so >>> fills correctly every step.
   assign step   = (cnt_q > STEP) ? STEP : cnt_q;
   assign last   = (cnt_q <= STEP);
   assign sh_r   = arith_q ?
                   $unsigned($signed(acc_q) >>> step) :
                   acc_q >> step;
   assign sh_l   = acc_q << step;
   assign sh_val = dir_q ? sh_r : sh_l;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      arith_d = arith_q;
      wop_d   = wop_q;
      if (flush) begin
         state_d = S_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end else if (accept) begin
         wop_d   = wop;
         arith_d = insn30;
         dir_d   = (funct3 == F_SR);
         if (is_shift && (amt != '0)) begin
            state_d = S_SHIFT;
            acc_d   = (funct3 == F_SR) ? sr_src : op1;
            cnt_d   = {1'b0, amt};
         end else begin
            state_d = S_DONE;
            acc_d   = quick;
            cnt_d   = '0;
         end
      end else begin
         case (state_q)
            S_SHIFT: begin
               cnt_d = cnt_q - step;
               if (last) begin
                  state_d = S_DONE;
                  acc_d   = wext(sh_val, wop_q);
               end else begin
                  acc_d = sh_val;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_d = S_IDLE;
               end
            end
            S_IDLE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         arith_q <= 1'b0;
         wop_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         arith_q <= arith_d;
         wop_q   <= wop_d;
      end
   end

   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_SHIFT);
   assign result    = acc_q;

endmodule
